// File: rtl/regfile_param.sv
// Parameterised register file with a per-register pending bit for issue scoreboarding.
// Optional same-cycle write-to-read bypass is compiled in with `define REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_writeEnable,
  input  logic [AW-1:0]    ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic             ctrl_reserveEnable,
  input  logic [AW-1:0]    ctrl_reserveReg,
  input  logic [AW-1:0]    ctrl_readRegA,
  input  logic [AW-1:0]    ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  output logic             busy_readRegA,
  output logic             busy_readRegB
);

  if (DEPTH < 2 || DEPTH > 64 || (64'd1 << AW) < 64'(DEPTH)) begin : gen_param_check
    $error("regfile_param: DEPTH must be 2..64 and fit in AW address bits");
  end

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Entry 0 is never written; addresses >= DEPTH never match any loop index.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ctrl_writeEnable && ctrl_writeReg == AW'(i)) begin
        regs_d[i] = data_writeReg;
        pend_d[i] = 1'b0;
      end
      // A reserve landing with a write to the same register is the newer producer.
      if (ctrl_reserveEnable && ctrl_reserveReg == AW'(i)) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    busy_readRegA = 1'b0;
    busy_readRegB = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ctrl_readRegA == AW'(i)) begin
        data_readRegA = regs_q[i];
        busy_readRegA = pend_q[i];
      end
      if (ctrl_readRegB == AW'(i)) begin
        data_readRegB = regs_q[i];
        busy_readRegB = pend_q[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (ctrl_writeEnable && ctrl_reset && ctrl_writeReg == AW'(i)) begin
        if (ctrl_readRegA == AW'(i)) begin
          data_readRegA = data_writeReg;
          busy_readRegA = pend_d[i];
        end
        if (ctrl_readRegB == AW'(i)) begin
          data_readRegB = data_writeReg;
          busy_readRegB = pend_d[i];
        end
      end
`endif
    end
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: data bits per register.
REQ-002 SHALL provide parameter DEPTH, default 32: register count, legal range 2..64.
REQ-003 SHALL provide parameter AW, default 5: address bits, with 2^AW >= DEPTH.
REQ-004 SHALL provide port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL provide port ctrl_reset, input, 1: synchronous reset, active-low.
REQ-006 SHALL provide port ctrl_writeEnable, input, 1: write strobe.
REQ-007 SHALL provide port ctrl_writeReg, input, AW: write address.
REQ-008 SHALL provide port data_writeReg, input, WIDTH: write data.
REQ-009 SHALL provide port ctrl_reserveEnable, input, 1: mark a register pending (producer issued).
REQ-010 SHALL provide port ctrl_reserveReg, input, AW: register to mark pending.
REQ-011 SHALL provide ports ctrl_readRegA and ctrl_readRegB, input, AW each: read addresses.
REQ-012 SHALL provide ports data_readRegA and data_readRegB, output, WIDTH each: read data.
REQ-013 SHALL provide ports busy_readRegA and busy_readRegB, output, 1 each: pending bit of the addressed register.

Function
REQ-014 SHALL hold DEPTH registers and DEPTH pending bits.
REQ-015 SHALL store data_writeReg into register ctrl_writeReg at a rising edge when ctrl_writeEnable=1 and ctrl_reset=1.
REQ-016 SHALL hardwire register 0: writes ignored, reads return 0, pending bit always 0.
REQ-017 SHALL ignore writes and reserves to addresses >= DEPTH; reads of such addresses return 0 with busy 0.
REQ-018 SHALL drive read data and busy outputs combinationally from current state and inputs, with zero-cycle latency.
REQ-019 SHALL set the pending bit of ctrl_reserveReg at a rising edge when ctrl_reserveEnable=1.
REQ-020 SHALL clear the pending bit of ctrl_writeReg at a rising edge when ctrl_writeEnable=1.
REQ-021 SHALL leave the pending bit set when reserve and write target the same register in the same cycle, since the newer producer wins; the data write still occurs.
REQ-022 SHALL allow reserve and write to different registers in the same cycle, each acting independently.
REQ-023 SHALL allow both read ports to address the same register and return identical values.

Reset
REQ-024 SHALL clear every register and every pending bit to 0 at a rising edge with ctrl_reset=0.
REQ-025 SHALL give reset priority over simultaneous write or reserve; both are discarded.
REQ-026 SHALL output data_readRegA/B = 0 and busy_readRegA/B = 0 for every address in the cycle after a reset edge, absent bypass.

Configuration
REQ-027 SHALL compile write-to-read bypass in when macro REGFILE_BYPASS_EN is defined.
  - Condition: ctrl_writeEnable=1, ctrl_reset=1, address nonzero and < DEPTH, and a read port addresses ctrl_writeReg.
  - Read data: that port returns data_writeReg in the same cycle.
  - Busy: that port returns the post-edge pending value (per REQ-021).
REQ-028 SHALL, without REGFILE_BYPASS_EN, return the stored (pre-edge) data and pending bit in the write cycle; the new value appears the cycle after the edge.

Verification
REQ-029 SHALL cover basic write/read.
  - Stimulus: write r5=0xDEADBEEF; next cycle read A=5, B=5.
  - Response: both data ports 0xDEADBEEF.
REQ-030 SHALL cover register 0.
  - Stimulus: write r0=0xFFFFFFFF and reserve r0.
  - Response: read A=0 gives data 0, busy 0.
REQ-031 SHALL cover the scoreboard.
  - Stimulus: reserve r7; next cycle read B=7; then write r7=0x12.
  - Response: busy_readRegB=1 after the reserve; busy=0 and data 0x12 after the write.
REQ-032 SHALL cover simultaneous reserve and write.
  - Stimulus: reserve r9 and write r9=0x34 in the same cycle.
  - Response: next cycle data 0x34, busy 1.
REQ-033 SHALL cover bypass.
  - Stimulus: write r3=0xA5A5 while read A=3, with r3 previously 0x1.
  - Response: data_readRegA=0xA5A5 in the same cycle if REGFILE_BYPASS_EN is defined, else 0x1.
REQ-034 SHALL cover reset mid-operation.
  - Stimulus: fill r1..r31 and reserve r4; then hold ctrl_reset=0 one edge while writing r2=0x55.
  - Response: every read returns data 0, busy 0.
